video_shifter: RTL and testbench
================================

Name: video_shifter

Overview:
Pixel serialiser directly downstream of the video timer. It captures 16-bit framebuffer words on the timer's pixel-load strobe and double-buffers them. It shifts them out MSB-first, one pixel per pixel strobe, as 1-bit luminance. Timer blanking is delayed to line up with the shifted pixels, and timer syncs are registered for output.

Parameters:
BLANK_LATENCY, 1, number of clk_en periods the blanking inputs are delayed before gating pixel output (1..4)
WORD_BITS, 16, framebuffer word width and shifter length

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
clk_en  in  1  bus-rate enable; one pulse per timer xpos step
pix_en  in  1  pixel strobe; nominally 4 pulses per clk_en period; may coincide with clk_en
loadPixels  in  1  from timer; word-fetch strobe, qualified by clk_en
dataIn  in  WORD_BITS  framebuffer word from RAM data bus, valid when clk_en & loadPixels
_hblank  in  1  from timer, active-low horizontal blank
_vblank  in  1  from timer, active-low vertical blank
hsync_in  in  1  from timer, active-low
vsync_in  in  1  from timer, active-low
pixel  out  1  luminance, 1 = white (framebuffer 1 = black, so inverted)
hsync  out  1  registered hsync_in
vsync  out  1  registered vsync_in
de  out  1  display enable; delayed (_hblank & _vblank)

Behaviour:
- Reset (async, active-high):
  - hold=0, hold_valid=0, shreg=0, bitcnt=0.
  - Blank delay line all 0; de=0; pixel=0.
  - hsync=1, vsync=1.
- Capture: on clk & clk_en & loadPixels: hold<=dataIn, hold_valid<=1. Capture is independent of pix_en.
- Shift, on clk & pix_en:
  - bitcnt!=0: pixel<=~shreg[WORD_BITS-1] & de; shreg<=shreg<<1; bitcnt<=bitcnt-1.
  - bitcnt==0 and hold_valid: pixel<=~hold[WORD_BITS-1] & de; shreg<=hold<<1; bitcnt<=WORD_BITS-1; hold_valid<=0.
  - bitcnt==0 and !hold_valid: underrun. pixel<=0; shreg and bitcnt unchanged.
- Simultaneous capture and transfer in one clk: transfer uses the old hold; new dataIn lands in hold; hold_valid ends at 1.
- Capture while hold_valid=1 and no transfer: hold is overwritten (overrun). The newest word wins; the old word is lost.
- Output latency: a bit is visible on pixel one clk after its pix_en edge. First pixel of a word appears ≥1 clk after its loadPixels capture.
- Blank delay: on clk & clk_en, a BLANK_LATENCY-deep shift line takes (_hblank & _vblank). de = last stage.
- When de=0: pixel is forced 0 at every pix_en. Shifting continues, so a word straddling a blank edge is consumed normally.
- Syncs: hsync<=hsync_in, vsync<=vsync_in on every clk & clk_en. There is no extra latency beyond this register; the timer already compensates for the pixel latency.
- bitcnt is log2(WORD_BITS) bits wide and wraps only through the reload path; it never decrements below 0.
- Reset mid-line: all state clears immediately. The first post-reset pixel is 0 until a word has been captured and transferred.

Optional Feature:
VIDEO_SHIFTER_UNDERRUN_EN:
- Defined:
  - Adds output underrun (1 bit) and output underrun_count (8 bits).
  - underrun pulses for one clk on each underrun pix_en while de=1.
  - underrun_count saturates at 255, clears on reset, and is also cleared by the rising edge of the delayed vblank (start of frame).
- Undefined: ports absent; underrun events are silently output as 0.

Test Plan:
1. Reset with hsync_in=0 held -> pixel=0, de=0, hsync=1 until first clk_en after reset; then hsync=0.
2. de=1, load dataIn=16'hA5F0, then 16 pix_en -> pixel sequence 0,1,0,1,1,0,1,0,0,0,0,0,1,1,1,1, each one clk after its pix_en.
3. Load 16'h8000, then load 16'hFFFF on the clk of the 16th-bit transfer -> second word's 16 pixels all 0 follow contiguously; no gap; hold_valid=0 after them.
4. BLANK_LATENCY=1, _hblank falls mid-word -> de falls one clk_en later; remaining pixels output 0; next word after _hblank rises displays correctly from its first bit.
5. pix_en continues 20 strobes after one word with de=1 (feature on) -> last 4 strobes give pixel=0, underrun pulses 4 times, underrun_count=4.
6. Two loads 16'h1234, 16'h5678 with no pix_en between -> only 16'h5678 is shifted out (overrun, newest wins).

Source files
------------

// File: rtl/video_shifter.sv
// video_shifter: 1-bit pixel serialiser behind the video timer.
// Captures framebuffer words on the timer's load strobe into a hold register,
// then moves them into a shift register and sends them out MSB-first, one bit
// per pix_en. Timer blanking passes through a BLANK_LATENCY-deep delay line to
// form de, which gates the pixel. The timer syncs are registered.
// Optional build macro: VIDEO_SHIFTER_UNDERRUN_EN adds the underrun pulse and
// the saturating per-frame underrun counter.
module video_shifter #(
  parameter int BLANK_LATENCY = 1,
  parameter int WORD_BITS     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clk_en,
  input  logic                 pix_en,
  input  logic                 loadPixels,
  input  logic [WORD_BITS-1:0] dataIn,
  input  logic                 _hblank,
  input  logic                 _vblank,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  output logic                 pixel,
  output logic                 hsync,
  output logic                 vsync,
`ifdef VIDEO_SHIFTER_UNDERRUN_EN
  output logic                 underrun,
  output logic [7:0]           underrun_count,
`endif
  output logic                 de
);

  localparam int CNT_W = $clog2(WORD_BITS);

  logic [WORD_BITS-1:0]     hold_r, hold_n_s;
  logic                     hold_valid_r, hold_valid_n_s;
  logic [WORD_BITS-1:0]     shreg_r, shreg_n_s;
  logic [CNT_W-1:0]         bitcnt_r, bitcnt_n_s;
  logic                     pixel_r, pixel_n_s;
  logic                     hsync_r, vsync_r;
  logic [BLANK_LATENCY-1:0] blank_line_r;

  logic capture_s;
  logic cnt_zero_s;
  logic de_s;

  assign capture_s  = clk_en & loadPixels;
  assign cnt_zero_s = (bitcnt_r == {CNT_W{1'b0}});
  assign de_s       = blank_line_r[BLANK_LATENCY-1];

  // Next-state for the hold buffer, shifter, bit counter and pixel bit.
  always_comb begin
    hold_n_s       = hold_r;
    hold_valid_n_s = hold_valid_r;
    shreg_n_s      = shreg_r;
    bitcnt_n_s     = bitcnt_r;
    pixel_n_s      = pixel_r;

    if (pix_en) begin
      if (!cnt_zero_s) begin
        pixel_n_s  = ~shreg_r[WORD_BITS-1] & de_s;
        shreg_n_s  = shreg_r << 1;
        bitcnt_n_s = bitcnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (hold_valid_r) begin
        // Transfer reads the old hold; a same-cycle capture below wins hold_valid.
        pixel_n_s      = ~hold_r[WORD_BITS-1] & de_s;
        shreg_n_s      = hold_r << 1;
        bitcnt_n_s     = CNT_W'(WORD_BITS - 1);
        hold_valid_n_s = 1'b0;
      end else begin
        // Underrun: nothing to show, shifter state stays put.
        pixel_n_s = 1'b0;
      end
    end else begin
      pixel_n_s = pixel_r;
    end

    if (capture_s) begin
      // Newest word always wins, even if the previous one was never shown.
      hold_n_s       = dataIn;
      hold_valid_n_s = 1'b1;
    end else begin
      hold_n_s = hold_r;
    end
  end

  // Shifter datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_r       <= {WORD_BITS{1'b0}};
      hold_valid_r <= 1'b0;
      shreg_r      <= {WORD_BITS{1'b0}};
      bitcnt_r     <= {CNT_W{1'b0}};
      pixel_r      <= 1'b0;
    end else begin
      hold_r       <= hold_n_s;
      hold_valid_r <= hold_valid_n_s;
      shreg_r      <= shreg_n_s;
      bitcnt_r     <= bitcnt_n_s;
      pixel_r      <= pixel_n_s;
    end
  end

  // Blank delay line and sync registers, advanced at bus rate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_line_r <= {BLANK_LATENCY{1'b0}};
      hsync_r      <= 1'b1;
      vsync_r      <= 1'b1;
    end else if (clk_en) begin
      blank_line_r[0] <= _hblank & _vblank;
      for (int i = 1; i < BLANK_LATENCY; i++) begin
        blank_line_r[i] <= blank_line_r[i-1];
      end
      hsync_r <= hsync_in;
      vsync_r <= vsync_in;
    end
  end

  assign pixel = pixel_r;
  assign hsync = hsync_r;
  assign vsync = vsync_r;
  assign de    = de_s;

`ifdef VIDEO_SHIFTER_UNDERRUN_EN
  logic [BLANK_LATENCY-1:0] vblank_line_r;
  logic                     vblank_prev_r;
  logic                     underrun_r;
  logic [7:0]               underrun_count_r;
  logic                     underrun_s;
  logic                     frame_start_s;

  assign underrun_s    = pix_en & cnt_zero_s & ~hold_valid_r & de_s;
  assign frame_start_s = vblank_line_r[BLANK_LATENCY-1] & ~vblank_prev_r;

  // Delayed _vblank, aligned with de, used to find the start of each frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_line_r <= {BLANK_LATENCY{1'b0}};
    end else if (clk_en) begin
      vblank_line_r[0] <= _vblank;
      for (int i = 1; i < BLANK_LATENCY; i++) begin
        vblank_line_r[i] <= vblank_line_r[i-1];
      end
    end
  end

  // Underrun pulse and saturating counter cleared at each frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vblank_prev_r    <= 1'b0;
      underrun_r       <= 1'b0;
      underrun_count_r <= 8'd0;
    end else begin
      vblank_prev_r <= vblank_line_r[BLANK_LATENCY-1];
      underrun_r    <= underrun_s;
      if (frame_start_s) begin
        underrun_count_r <= 8'd0;
      end else if (underrun_s && (underrun_count_r != 8'hFF)) begin
        underrun_count_r <= underrun_count_r + 8'd1;
      end
    end
  end

  assign underrun       = underrun_r;
  assign underrun_count = underrun_count_r;
`endif

endmodule

// File: tb/tb_video_shifter.sv
// Directed self-checking bench for video_shifter (default parameters).
// Underrun port checks are included when VIDEO_SHIFTER_UNDERRUN_EN is defined.
module tb_video_shifter;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_en;
  logic        pix_en;
  logic        loadPixels;
  logic [15:0] dataIn;
  logic        hblank_n;
  logic        vblank_n;
  logic        hsync_in;
  logic        vsync_in;
  logic        pixel;
  logic        hsync;
  logic        vsync;
  logic        de;
`ifdef VIDEO_SHIFTER_UNDERRUN_EN
  logic        underrun;
  logic [7:0]  underrun_count;
`endif

  int checks = 0;
  int errors = 0;

  video_shifter dut (
    .clk           (clk),
    .reset         (reset),
    .clk_en        (clk_en),
    .pix_en        (pix_en),
    .loadPixels    (loadPixels),
    .dataIn        (dataIn),
    ._hblank       (hblank_n),
    ._vblank       (vblank_n),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .pixel         (pixel),
    .hsync         (hsync),
    .vsync         (vsync),
`ifdef VIDEO_SHIFTER_UNDERRUN_EN
    .underrun      (underrun),
    .underrun_count(underrun_count),
`endif
    .de            (de)
  );

  always #5 clk = ~clk;

  // One clock with the given strobes; outputs are sampled 1 time unit after the edge.
  task automatic cycle(input logic ce, input logic pe, input logic ld, input logic [15:0] d);
    clk_en     = ce;
    pix_en     = pe;
    loadPixels = ld;
    dataIn     = d;
    @(posedge clk);
    #1;
    clk_en     = 1'b0;
    pix_en     = 1'b0;
    loadPixels = 1'b0;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_bits;

    reset = 1'b1; clk_en = 1'b0; pix_en = 1'b0; loadPixels = 1'b0; dataIn = 16'h0000;
    hblank_n = 1'b1; vblank_n = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;

    // 1: reset state, syncs held high until the first clk_en after reset
    cycle(1'b1, 1'b1, 1'b1, 16'hFFFF);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    check("rst_pixel", {7'd0, pixel}, 8'd0);
    check("rst_de",    {7'd0, de},    8'd0);
    check("rst_hsync", {7'd0, hsync}, 8'd1);
    check("rst_vsync", {7'd0, vsync}, 8'd1);
    reset = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    check("post_rst_hsync_hold", {7'd0, hsync}, 8'd1);
    check("post_rst_pix_underrun", {7'd0, pixel}, 8'd0);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    check("first_ce_hsync", {7'd0, hsync}, 8'd0);
    check("first_ce_vsync", {7'd0, vsync}, 8'd0);
    check("first_ce_de",    {7'd0, de},    8'd1);
    hsync_in = 1'b1; vsync_in = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    check("hsync_rise", {7'd0, hsync}, 8'd1);

    // 2: A5F0 shifted MSB-first, inverted
    cycle(1'b1, 1'b0, 1'b1, 16'hA5F0);
    exp_bits = 16'b0101101000001111;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      check($sformatf("a5f0_bit%0d", i), {7'd0, pixel}, {7'd0, exp_bits[15-i]});
    end

    // 3: 8000 then FFFF captured on the clk 8000 is transferred; contiguous output
    cycle(1'b1, 1'b0, 1'b1, 16'h8000);
    cycle(1'b1, 1'b1, 1'b1, 16'hFFFF);
    check("w8000_bit0", {7'd0, pixel}, 8'd0);
    for (int i = 1; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      check($sformatf("w8000_bit%0d", i), {7'd0, pixel}, 8'd1);
    end
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      check($sformatf("wffff_bit%0d", i), {7'd0, pixel}, 8'd0);
    end
    // Hold must now be empty: the next strobe is an underrun
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    check("after_ffff_underrun_pix", {7'd0, pixel}, 8'd0);
`ifdef VIDEO_SHIFTER_UNDERRUN_EN
    check("after_ffff_underrun_flag", {7'd0, underrun}, 8'd1);
`endif

    // 4: _hblank falls mid-word, de follows one clk_en later
    cycle(1'b1, 1'b0, 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      check($sformatf("blank_pre_bit%0d", i), {7'd0, pixel}, 8'd1);
    end
    hblank_n = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    check("de_waits_for_ce", {7'd0, de},    8'd1);
    check("blank_bit4",      {7'd0, pixel}, 8'd1);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    check("de_fell", {7'd0, de}, 8'd0);
    for (int i = 5; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      check($sformatf("blank_gated_bit%0d", i), {7'd0, pixel}, 8'd0);
    end
    hblank_n = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, 16'h0F0F);
    check("de_rose", {7'd0, de}, 8'd1);
    exp_bits = 16'b1111000011110000;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      check($sformatf("w0f0f_bit%0d", i), {7'd0, pixel}, {7'd0, exp_bits[15-i]});
    end

    // 6: two loads with no pix_en between, newest wins
    cycle(1'b1, 1'b0, 1'b1, 16'h1234);
    cycle(1'b1, 1'b0, 1'b1, 16'h5678);
    exp_bits = 16'b1010100110000111;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      check($sformatf("overrun_bit%0d", i), {7'd0, pixel}, {7'd0, exp_bits[15-i]});
    end

    // 5: one word then 20 strobes, last 4 are underruns
    reset = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    check("midrst_de",    {7'd0, de},    8'd0);
    check("midrst_pixel", {7'd0, pixel}, 8'd0);
    reset = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 16'h00FF);
    exp_bits = 16'b1111111100000000;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 16'h0000);
      if (i < 16) begin
        check($sformatf("ur_word_bit%0d", i), {7'd0, pixel}, {7'd0, exp_bits[15-i]});
      end else begin
        check($sformatf("ur_pix%0d", i), {7'd0, pixel}, 8'd0);
      end
`ifdef VIDEO_SHIFTER_UNDERRUN_EN
      check($sformatf("ur_flag%0d", i), {7'd0, underrun}, {7'd0, (i >= 16)});
`endif
    end
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
`ifdef VIDEO_SHIFTER_UNDERRUN_EN
    check("ur_pulse_ends", {7'd0, underrun}, 8'd0);
    check("ur_count",      underrun_count,   8'd4);
`endif
    check("ur_pixel_idle", {7'd0, pixel}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
